dcache_direct: RTL and testbench
================================

// Module: dcache_direct
// PURPOSE
//  Direct-mapped, write-through, no-write-allocate data cache placed between the execute/memory
//  pipeline stage and the data memory. One 32-bit word per line. Load hits return in the same
//  cycle. Misses and all stores stall the pipeline until the backing memory handshake completes.
//  Performs lb/lh/lw/lbu/lhu formatting and sb/sh/sw byte-lane enables toward the backing memory.
// PARAMETERS
//  DATA_WIDTH  32   word width; fixed at 32
//  ADDR_WIDTH  17   byte address width
//  SETS        256  number of lines, power of 2; IDX = $clog2(SETS)
// PORTS
//  clk        in   1           rising-edge clock
//  rst_n      in   1           async active-low reset
//  SizeCtr    in   3           000 b, 001 h, 010 w, 100 bu, 101 hu
//  ALUResult  in   ADDR_WIDTH  byte address; held stable while Stall=1
//  WriteData  in   32          store data, right-aligned
//  MemWrite   in   1           store request
//  MemRead    in   1           load request
//  ReadData   out  32          formatted load data
//  Stall      out  1           pipeline must hold the request
//  MemAddr    out  ADDR_WIDTH  word address to backing memory ({ALUResult[ADDR_WIDTH-1:2],2'b00})
//  MemWData   out  32          store data, lane-shifted
//  MemByteEn  out  4           store byte enables
//  MemRE      out  1           backing read strobe
//  MemWE      out  1           backing write strobe
//  MemRData   in   32          backing read word
//  MemReady   in   1           backing access done this cycle
//  HitCount   out  32          load hits, saturating
//  MissCount  out  32          load misses, saturating
// BEHAVIOUR
//  Address split: off=ALUResult[1:0], idx=ALUResult[IDX+1:2], tag=ALUResult[ADDR_WIDTH-1:IDX+2].
//  Storage per line: valid, tag, 32-bit data. hit = valid[idx] & tag match.
//  Lanes: byte at off; half at ALUResult[1]*2 (off[0] ignored); word ignores off.
//  Load format: sign-extend for b/h, zero-extend for bu/hu. ReadData=0 when no valid load.
//  Valid load: MemRead=1, MemWrite=0, SizeCtr in {000,001,010,100,101}.
//  Valid store: MemWrite=1, SizeCtr in {000,001,010}.
//  MemWrite has priority over MemRead. Invalid SizeCtr => no access, Stall=0, no counting.
//  FSM states: IDLE, FILL, STORE.
//   IDLE, load hit: ReadData from line, Stall=0, HitCount+1 at the clock edge.
//   IDLE, load miss: Stall=1, MissCount+1, next state FILL.
//   IDLE, store: Stall=1, next state STORE (hit or miss).
//   FILL: MemRE=1. While MemReady=0, Stall=1.
//     On MemReady=1: Stall=0, ReadData formatted from MemRData, line written
//     (valid=1, tag, data), next state IDLE.
//   STORE: MemWE=1, MemByteEn/MemWData per lanes. While MemReady=0, Stall=1.
//     On MemReady=1: Stall=0. If hit, only the enabled bytes of the line are updated.
//     Miss does not allocate. Next state IDLE.
//  MemRE and MemWE are never both 1. Both are 0 in IDLE. MemAddr is driven in all states.
//  Counters saturate at 32'hFFFF_FFFF.
//  Reset (async, any state): state=IDLE, all valid=0, counters=0.
//    MemRE, MemWE, MemByteEn and Stall drop immediately. Line data/tag are not reset.
//  Reset mid-FILL/STORE aborts the access. No line update occurs.
//  Back-to-back: a request presented in the cycle after completion is handled from IDLE.
// TESTING
//  1 Reset, then lw 0x100 with MemReady after 3 cycles, MemRData=0x8899AABB.
//    -> Stall 1 for 3 cycles, ReadData 0x8899AABB on the ready cycle, MissCount=1.
//    Repeat lw 0x100 -> Stall=0, same data, HitCount=1.
//  2 Line 0x100 = 0x8899AABB: lb 0x101 -> 0xFFFFFFAA; lbu 0x101 -> 0x000000AA;
//    lh 0x102 -> 0xFFFF8899; lhu 0x102 -> 0x00008899. All are hits with Stall=0.
//  3 sb 0x103 WriteData=0x11 on a hit line -> MemByteEn=1000, MemWData[31:24]=0x11.
//    Then lw 0x100 hit -> 0x1199AABB.
//  4 sh 0x2002 on a miss -> MemByteEn=1100, MemWE until MemReady.
//    Then lw 0x2000 -> miss (no allocate). MemRead+MemWrite together -> store only.
//  5 Aliasing: lw 0x0000 then lw 0x0400 (SETS=256) -> second is a miss and evicts.
//    lw 0x0000 again -> miss. Invalid SizeCtr 011 load -> ReadData=0, Stall=0.
//  6 Assert rst_n low mid-FILL -> MemRE=0, Stall=0 immediately.
//    After release, prior line address misses. Counters saturate when preloaded near max.

Source files
------------

// File: rtl/dcache_direct.sv
// Direct-mapped write-through, no-write-allocate data cache, one 32-bit word per line.
// Latency: load hit returns combinationally in the request cycle; misses/stores wait on MemReady.
// Backpressure: Stall holds the pipeline while a fill or store is outstanding to backing memory.
module dcache_direct #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 17,
  parameter int SETS       = 256
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [2:0]            SizeCtr,
  input  logic [ADDR_WIDTH-1:0] ALUResult,
  input  logic [DATA_WIDTH-1:0] WriteData,
  input  logic                  MemWrite,
  input  logic                  MemRead,
  output logic [DATA_WIDTH-1:0] ReadData,
  output logic                  Stall,
  output logic [ADDR_WIDTH-1:0] MemAddr,
  output logic [DATA_WIDTH-1:0] MemWData,
  output logic [3:0]            MemByteEn,
  output logic                  MemRE,
  output logic                  MemWE,
  input  logic [DATA_WIDTH-1:0] MemRData,
  input  logic                  MemReady,
  output logic [31:0]           HitCount,
  output logic [31:0]           MissCount
);

  localparam int IDX  = $clog2(SETS);
  localparam int TAGW = ADDR_WIDTH - IDX - 2;

  typedef enum logic [1:0] {IDLE, FILL, STORE} state_t;

  state_t            state;
  logic [SETS-1:0]   valid_q;
  logic [TAGW-1:0]   tag_mem  [SETS];
  logic [31:0]       data_mem [SETS];
  logic [31:0]       hit_cnt;
  logic [31:0]       miss_cnt;

  logic [1:0]        off;
  logic [IDX-1:0]    idx;
  logic [TAGW-1:0]   tag;
  logic              line_hit;
  logic              load_size_ok;
  logic              store_size_ok;
  logic              is_load;
  logic              is_store;
  logic [3:0]        lane_be;
  logic [31:0]       lane_wd;
  logic [31:0]       merged;
  logic              stall_c;
  logic              fill_done;
  logic              store_done;

  assign off = ALUResult[1:0];
  assign idx = ALUResult[IDX+1:2];
  assign tag = ALUResult[ADDR_WIDTH-1:IDX+2];

  assign load_size_ok  = (SizeCtr == 3'b000) || (SizeCtr == 3'b001) || (SizeCtr == 3'b010) ||
                         (SizeCtr == 3'b100) || (SizeCtr == 3'b101);
  assign store_size_ok = (SizeCtr == 3'b000) || (SizeCtr == 3'b001) || (SizeCtr == 3'b010);

  // A write request always wins; a load is only taken when no write is asked for.
  assign is_store = MemWrite && store_size_ok;
  assign is_load  = !MemWrite && MemRead && load_size_ok;

  assign line_hit   = valid_q[idx] && (tag_mem[idx] == tag);
  assign fill_done  = (state == FILL) && MemReady;
  assign store_done = (state == STORE) && MemReady;

  // Extract and extend the addressed byte/half/word from a full line word.
  function automatic logic [31:0] fmt_load(input logic [31:0] w, input logic [2:0] sz,
                                           input logic [1:0] o);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (o)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    h = o[1] ? w[31:16] : w[15:0];
    case (sz)
      3'b000:  r = {{24{b[7]}}, b};
      3'b001:  r = {{16{h[15]}}, h};
      3'b010:  r = w;
      3'b100:  r = {24'd0, b};
      3'b101:  r = {16'd0, h};
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  // Store lane steering: byte enables and data shifted into the addressed lanes.
  always_comb begin
    lane_be = 4'b0000;
    lane_wd = 32'd0;
    case (SizeCtr)
      3'b000: begin
        lane_be = 4'b0001 << off;
        lane_wd = {24'd0, WriteData[7:0]} << {off, 3'b000};
      end
      3'b001: begin
        lane_be = ALUResult[1] ? 4'b1100 : 4'b0011;
        lane_wd = ALUResult[1] ? {WriteData[15:0], 16'd0} : {16'd0, WriteData[15:0]};
      end
      3'b010: begin
        lane_be = 4'b1111;
        lane_wd = WriteData;
      end
      default: begin
        lane_be = 4'b0000;
        lane_wd = 32'd0;
      end
    endcase
  end

  // Byte-merge of store data into the currently cached word, used on a store hit.
  always_comb begin
    merged = data_mem[idx];
    for (int i = 0; i < 4; i++) begin
      if (lane_be[i]) merged[8*i +: 8] = lane_wd[8*i +: 8];
    end
  end

  // Stall decode: request-dependent in IDLE, handshake-dependent while an access is open.
  always_comb begin
    stall_c = 1'b0;
    case (state)
      IDLE:    stall_c = is_store || (is_load && !line_hit);
      FILL:    stall_c = !MemReady;
      STORE:   stall_c = !MemReady;
      default: stall_c = 1'b0;
    endcase
  end

  // Reset forces Stall low at once even though the held request would otherwise miss.
  assign Stall = rst_n & stall_c;

  // Load data: line on an IDLE hit, backing word on fill completion, otherwise zero.
  always_comb begin
    ReadData = 32'd0;
    if ((state == IDLE) && is_load && line_hit) begin
      ReadData = fmt_load(data_mem[idx], SizeCtr, off);
    end else if (fill_done) begin
      ReadData = fmt_load(MemRData, SizeCtr, off);
    end
  end

  assign MemAddr   = {ALUResult[ADDR_WIDTH-1:2], 2'b00};
  assign MemWData  = lane_wd;
  assign MemByteEn = (state == STORE) ? lane_be : 4'b0000;
  assign MemRE     = (state == FILL);
  assign MemWE     = (state == STORE);
  assign HitCount  = hit_cnt;
  assign MissCount = miss_cnt;

  // Access sequencer: IDLE dispatches misses to FILL and every store to STORE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (is_store)                 state <= STORE;
          else if (is_load && !line_hit) state <= FILL;
        end
        FILL:    if (MemReady) state <= IDLE;
        STORE:   if (MemReady) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Valid bits: cleared by reset, set when a fill completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else if (fill_done) begin
      valid_q[idx] <= 1'b1;
    end
  end

  // Tag/data arrays are not reset; valid bits alone qualify their contents.
  always_ff @(posedge clk) begin
    if (fill_done) begin
      tag_mem[idx]  <= tag;
      data_mem[idx] <= MemRData;
    end else if (store_done && line_hit) begin
      data_mem[idx] <= merged;
    end
  end

  // Saturating hit/miss statistics, counted once per load as it is seen in IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_cnt  <= 32'd0;
      miss_cnt <= 32'd0;
    end else if ((state == IDLE) && is_load) begin
      if (line_hit) begin
        if (hit_cnt != 32'hFFFF_FFFF) hit_cnt <= hit_cnt + 32'd1;
      end else begin
        if (miss_cnt != 32'hFFFF_FFFF) miss_cnt <= miss_cnt + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_dcache_direct.sv
// Directed bench for dcache_direct: fills, hits, load formatting, stores, aliasing, reset, saturation.
// Inputs change 1 ns after the rising edge; outputs are checked 1-2 ns after the edge.
// Backing memory is played by hand through MemReady/MemRData.
module tb_dcache_direct;

  logic        clk;
  logic        rst_n;
  logic [2:0]  SizeCtr;
  logic [16:0] ALUResult;
  logic [31:0] WriteData;
  logic        MemWrite;
  logic        MemRead;
  logic [31:0] ReadData;
  logic        Stall;
  logic [16:0] MemAddr;
  logic [31:0] MemWData;
  logic [3:0]  MemByteEn;
  logic        MemRE;
  logic        MemWE;
  logic [31:0] MemRData;
  logic        MemReady;
  logic [31:0] HitCount;
  logic [31:0] MissCount;

  int checks = 0;
  int errors = 0;

  dcache_direct #(.DATA_WIDTH(32), .ADDR_WIDTH(17), .SETS(256)) dut (
    .clk(clk), .rst_n(rst_n), .SizeCtr(SizeCtr), .ALUResult(ALUResult),
    .WriteData(WriteData), .MemWrite(MemWrite), .MemRead(MemRead),
    .ReadData(ReadData), .Stall(Stall), .MemAddr(MemAddr), .MemWData(MemWData),
    .MemByteEn(MemByteEn), .MemRE(MemRE), .MemWE(MemWE), .MemRData(MemRData),
    .MemReady(MemReady), .HitCount(HitCount), .MissCount(MissCount)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", name, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] sz, input logic [16:0] a, input logic [31:0] wd,
                       input logic we, input logic re);
    SizeCtr   = sz;
    ALUResult = a;
    WriteData = wd;
    MemWrite  = we;
    MemRead   = re;
    #1;
  endtask

  initial begin
    rst_n = 1'b0; SizeCtr = 3'b000; ALUResult = '0; WriteData = '0;
    MemWrite = 1'b0; MemRead = 1'b0; MemRData = '0; MemReady = 1'b0;
    tick(); tick();
    chk("rst_stall", {31'd0, Stall}, 32'd0);
    chk("rst_memre", {31'd0, MemRE}, 32'd0);
    chk("rst_memwe", {31'd0, MemWE}, 32'd0);
    chk("rst_hits", HitCount, 32'd0);
    chk("rst_miss", MissCount, 32'd0);
    rst_n = 1'b1;

    // lw 0x100 cold miss, ready on the third stalled cycle
    drive(3'b010, 17'h100, 32'd0, 1'b0, 1'b1);
    chk("t1_idle_stall", {31'd0, Stall}, 32'd1);
    chk("t1_idle_memre", {31'd0, MemRE}, 32'd0);
    chk("t1_memaddr", {15'd0, MemAddr}, 32'h100);
    tick();
    chk("t1_fill_memre", {31'd0, MemRE}, 32'd1);
    chk("t1_fill_stall1", {31'd0, Stall}, 32'd1);
    chk("t1_miss1", MissCount, 32'd1);
    tick();
    chk("t1_fill_stall2", {31'd0, Stall}, 32'd1);
    tick();
    MemReady = 1'b1; MemRData = 32'h8899_AABB; #1;
    chk("t1_ready_stall", {31'd0, Stall}, 32'd0);
    chk("t1_ready_data", ReadData, 32'h8899_AABB);
    tick();
    MemReady = 1'b0; MemRData = 32'd0; #1;
    chk("t1_hit_stall", {31'd0, Stall}, 32'd0);
    chk("t1_hit_data", ReadData, 32'h8899_AABB);
    chk("t1_hit_memre", {31'd0, MemRE}, 32'd0);
    tick();
    chk("t1_hits1", HitCount, 32'd1);

    // load formatting on the cached word 0x8899AABB
    drive(3'b000, 17'h101, 32'd0, 1'b0, 1'b1);
    chk("t2_lb", ReadData, 32'hFFFF_FFAA);
    chk("t2_lb_stall", {31'd0, Stall}, 32'd0);
    tick();
    drive(3'b100, 17'h101, 32'd0, 1'b0, 1'b1);
    chk("t2_lbu", ReadData, 32'h0000_00AA);
    tick();
    drive(3'b001, 17'h102, 32'd0, 1'b0, 1'b1);
    chk("t2_lh", ReadData, 32'hFFFF_8899);
    chk("t2_lh_stall", {31'd0, Stall}, 32'd0);
    tick();
    drive(3'b101, 17'h102, 32'd0, 1'b0, 1'b1);
    chk("t2_lhu", ReadData, 32'h0000_8899);
    tick();
    chk("t2_hits5", HitCount, 32'd5);

    // sb 0x103 on a hit line, then reload
    drive(3'b000, 17'h103, 32'h11, 1'b1, 1'b0);
    chk("t3_idle_stall", {31'd0, Stall}, 32'd1);
    chk("t3_idle_memwe", {31'd0, MemWE}, 32'd0);
    tick();
    chk("t3_memwe", {31'd0, MemWE}, 32'd1);
    chk("t3_memre", {31'd0, MemRE}, 32'd0);
    chk("t3_byteen", {28'd0, MemByteEn}, 32'h8);
    chk("t3_wdata_b3", {24'd0, MemWData[31:24]}, 32'h11);
    chk("t3_memaddr", {15'd0, MemAddr}, 32'h100);
    chk("t3_stall", {31'd0, Stall}, 32'd1);
    tick();
    MemReady = 1'b1; #1;
    chk("t3_done_stall", {31'd0, Stall}, 32'd0);
    tick();
    MemReady = 1'b0;
    drive(3'b010, 17'h100, 32'd0, 1'b0, 1'b1);
    chk("t3_reload", ReadData, 32'h1199_AABB);
    chk("t3_reload_stall", {31'd0, Stall}, 32'd0);
    tick();
    chk("t3_hits6", HitCount, 32'd6);

    // sh 0x2002 miss with MemRead also high: store only, no allocate
    drive(3'b001, 17'h2002, 32'h0000_BEEF, 1'b1, 1'b1);
    chk("t4_idle_stall", {31'd0, Stall}, 32'd1);
    tick();
    chk("t4_memwe", {31'd0, MemWE}, 32'd1);
    chk("t4_memre", {31'd0, MemRE}, 32'd0);
    chk("t4_byteen", {28'd0, MemByteEn}, 32'hC);
    chk("t4_wdata", MemWData, 32'hBEEF_0000);
    tick();
    chk("t4_wait_memwe", {31'd0, MemWE}, 32'd1);
    chk("t4_wait_stall", {31'd0, Stall}, 32'd1);
    MemReady = 1'b1; #1;
    chk("t4_done_stall", {31'd0, Stall}, 32'd0);
    tick();
    MemReady = 1'b0;
    chk("t4_after_memwe", {31'd0, MemWE}, 32'd0);
    chk("t4_miss_unchanged", MissCount, 32'd1);
    drive(3'b010, 17'h2000, 32'd0, 1'b0, 1'b1);
    chk("t4_noalloc_stall", {31'd0, Stall}, 32'd1);
    tick();
    chk("t4_miss2", MissCount, 32'd2);
    chk("t4_fill_memre", {31'd0, MemRE}, 32'd1);
    MemReady = 1'b1; MemRData = 32'h1234_5678; #1;
    chk("t4_fill_data", ReadData, 32'h1234_5678);
    tick();
    MemReady = 1'b0;

    // aliasing on set 0: 0x0000 and 0x0400 evict each other
    drive(3'b010, 17'h0000, 32'd0, 1'b0, 1'b1);
    chk("t5_a_stall", {31'd0, Stall}, 32'd1);
    tick();
    MemReady = 1'b1; MemRData = 32'hCAFE_F00D; #1;
    chk("t5_a_data", ReadData, 32'hCAFE_F00D);
    tick();
    MemReady = 1'b0;
    drive(3'b010, 17'h0400, 32'd0, 1'b0, 1'b1);
    chk("t5_b_stall", {31'd0, Stall}, 32'd1);
    tick();
    MemReady = 1'b1; MemRData = 32'h0BAD_BEEF; #1;
    chk("t5_b_data", ReadData, 32'h0BAD_BEEF);
    tick();
    MemReady = 1'b0;
    drive(3'b010, 17'h0000, 32'd0, 1'b0, 1'b1);
    chk("t5_evicted_stall", {31'd0, Stall}, 32'd1);
    tick();
    MemReady = 1'b1; MemRData = 32'hCAFE_F00D; #1;
    tick();
    MemReady = 1'b0;
    chk("t5_miss5", MissCount, 32'd5);
    drive(3'b011, 17'h0000, 32'd0, 1'b0, 1'b1);
    chk("t5_badsize_data", ReadData, 32'd0);
    chk("t5_badsize_stall", {31'd0, Stall}, 32'd0);
    tick();
    chk("t5_badsize_hits", HitCount, 32'd6);
    chk("t5_badsize_miss", MissCount, 32'd5);

    // reset asserted mid-FILL
    drive(3'b010, 17'h0800, 32'd0, 1'b0, 1'b1);
    tick();
    chk("t6_fill_memre", {31'd0, MemRE}, 32'd1);
    rst_n = 1'b0; #1;
    chk("t6_rst_memre", {31'd0, MemRE}, 32'd0);
    chk("t6_rst_stall", {31'd0, Stall}, 32'd0);
    chk("t6_rst_miss", MissCount, 32'd0);
    tick();
    rst_n = 1'b1;
    drive(3'b010, 17'h0000, 32'd0, 1'b0, 1'b1);
    chk("t6_invalidated_stall", {31'd0, Stall}, 32'd1);
    tick();
    chk("t6_miss1", MissCount, 32'd1);
    MemReady = 1'b1; MemRData = 32'hCAFE_F00D; #1;
    chk("t6_refill_data", ReadData, 32'hCAFE_F00D);
    tick();
    MemReady = 1'b0;

    // saturation: hit counter preloaded one below max, lw 0x0000 keeps hitting
    dut.hit_cnt = 32'hFFFF_FFFE;
    #1;
    chk("t6_hit_stall", {31'd0, Stall}, 32'd0);
    tick();
    chk("t6_hit_sat1", HitCount, 32'hFFFF_FFFF);
    tick();
    chk("t6_hit_sat2", HitCount, 32'hFFFF_FFFF);
    dut.miss_cnt = 32'hFFFF_FFFF;
    drive(3'b010, 17'h0400, 32'd0, 1'b0, 1'b1);
    tick();
    chk("t6_miss_sat", MissCount, 32'hFFFF_FFFF);
    MemReady = 1'b1; MemRData = 32'h0BAD_BEEF; #1;
    tick();
    MemReady = 1'b0;
    drive(3'b000, 17'h0000, 32'd0, 1'b0, 1'b0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
